// File: rtl/hex_scroll_feeder.sv
// Queues 4-bit hex symbols and presents each one on 'value' for HOLD_CYCLES clocks,
// so a queued message scrolls across the downstream seven-segment display.
module hex_scroll_feeder #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 10,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    value,
    output logic          value_valid,
    output logic [CW-1:0] fifo_count,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit keeps the counter at least 1 wide when HOLD_CYCLES is 1.
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHOW} state_t;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          vv_nxt;

    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count;
    assign busy       = (state == SHOW);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        pop       = 1'b0;
        vv_nxt    = value_valid;
        case (state)
            IDLE: begin
                vv_nxt = 1'b0;
                if (count != '0) begin
                    pop       = 1'b1;
                    vv_nxt    = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    // Pop decision looks only at the registered count: no pass-through.
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        vv_nxt    = 1'b0;
                        state_nxt = IDLE;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            value       <= 4'h0;
            value_valid <= 1'b0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            value_valid <= vv_nxt;
            if (pop) begin
                value  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule
